decoder_link_master: RTL

//  Host-side master for the decoder_top streaming interface. It latches one full LLR frame from
//  the host and splits it into N_LLRS-wide beats using the first_data/data_valid protocol. It then

---
 rtl/decoder_link_master.sv | 128 ++++++++++++
 1 files changed

// File: rtl/decoder_link_master.sv
// Host-side master for decoder_top: slices one latched LLR frame into input beats,
// then collects the decoded codeword from databus_out beats (with a ready timeout).
module decoder_link_master #(
  parameter int WIDTH_IN  = 4,
  parameter int N_LLRS    = 4,
  parameter int WIDTH_OUT = 4,
  parameter int N_V       = 10,
  parameter int TIMEOUT   = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH_IN*N_V-1:0]      frame_in,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  output logic [N_LLRS*WIDTH_IN-1:0]   dec_databus_in,
  output logic                         dec_first_data,
  output logic                         dec_data_valid,
  input  logic                         dec_busy,
  input  logic                         dec_out_ready,
  output logic                         dec_first_out,
  input  logic [WIDTH_OUT-1:0]         dec_databus_out,
  input  logic                         dec_valid_out,
  output logic [N_V-1:0]               cw_out,
  output logic                         cw_valid,
  input  logic                         cw_ack,
  output logic                         err
);
  localparam int FW        = WIDTH_IN * N_V;
  localparam int BW        = N_LLRS * WIDTH_IN;
  localparam int L_SEG     = (N_V - 1) / N_LLRS;
  localparam int FC        = ((N_V - 1) % N_LLRS + 1) * WIDTH_IN;
  localparam int L_SEG_OUT = (N_V - 1) / WIDTH_OUT;
  localparam int FCO       = (N_V - 1) % WIDTH_OUT + 1;
  localparam int MAXS      = (L_SEG > L_SEG_OUT) ? L_SEG : L_SEG_OUT;
  localparam int CNT_W     = $clog2(MAXS + 2);
  localparam int TW        = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, SEND_F, SEND, WAIT, RECV, DONE} state_t;

  state_t           state_q;
  logic [FW-1:0]    frame_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TW-1:0]    timer_q;
  logic [N_V-1:0]   cw_q;
  logic             err_q;

  assign frame_ready = (state_q == IDLE);
  assign cw_valid    = (state_q == DONE);
  assign cw_out      = cw_q;
  assign err         = err_q;

  // Beat strobes follow dec_busy/dec_out_ready combinationally so no cycle is lost.
  always_comb begin
    dec_databus_in = '0;
    dec_first_data = 1'b0;
    dec_data_valid = 1'b0;
    dec_first_out  = 1'b0;
    case (state_q)
      SEND_F: if (!dec_busy) begin
        dec_first_data = 1'b1;
        dec_data_valid = 1'b1;
        dec_databus_in = BW'(frame_q[FW-1 -: FC]);
      end
      SEND: begin
        dec_data_valid = 1'b1;
        dec_databus_in = frame_q[FW-1 -: BW];
      end
      WAIT:    dec_first_out = dec_out_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      cw_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (frame_valid) begin
          frame_q <= frame_in;
          cnt_q   <= '0;
          state_q <= SEND_F;
        end
        SEND_F: if (!dec_busy) begin
          frame_q <= frame_q << FC;
          timer_q <= '0;
          if (L_SEG == 0) state_q <= WAIT;
          else begin
            cnt_q   <= CNT_W'(1);
            state_q <= SEND;
          end
        end
        SEND: begin
          frame_q <= frame_q << BW;
          if (cnt_q == CNT_W'(L_SEG)) begin
            timer_q <= '0;
            state_q <= WAIT;
          end else cnt_q <= cnt_q + 1'b1;
        end
        WAIT: begin
          if (dec_out_ready) begin
            cnt_q   <= '0;
            state_q <= RECV;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            cw_q    <= '0;
            state_q <= DONE;
          end else timer_q <= timer_q + 1'b1;
        end
        RECV: if (dec_valid_out) begin
          // First word carries only the FCO leftover MSBs of the codeword.
          if (cnt_q == '0) cw_q <= N_V'(dec_databus_out[FCO-1:0]);
          else             cw_q <= N_V'({cw_q, dec_databus_out});
          if (cnt_q == CNT_W'(L_SEG_OUT)) begin
            err_q   <= 1'b0;
            state_q <= DONE;
          end else cnt_q <= cnt_q + 1'b1;
        end
        DONE: if (cw_ack) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
